debug_unit_ctrl: RTL and testbench

Debug-unit controller that sits directly upstream of the pipeline and drives its debug ports. It receives command bytes from the UART receiver and assembles program words, writing them into instruction memory. It gates the pipeline clock enable for run and step execution, and reports the halted PC back through the UART transmitter.

---
 rtl/dunit_pkg.sv | 26 ++
 rtl/debug_unit_ctrl_if.sv | 35 +++
 rtl/dunit_tx_serializer.sv | 57 +++++
 rtl/debug_unit_ctrl.sv | 145 ++++++++++++++
 tb/tb_debug_unit_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dunit_pkg.sv
// Shared constants and types for the debug-unit controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: UART command codes, controller state enum, UART byte width.
package dunit_pkg;

   localparam int NB_BYTE = 8;

   localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h43;  // 'C'
   localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;  // 'S'

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_CNT,
      LOAD_BYTE,
      LOAD_WRITE,
      RUN,
      STEP,
      SEND
   } dunit_state_t;

endpackage

// File: rtl/debug_unit_ctrl_if.sv
// Bundle of UART, pipeline-status and debug-port signals around the debug unit.
// Latency: n/a (wiring only).
// Backpressure: tx side uses a start/done handshake; rx side has none (strobe only).
//
// Modports: master = debug-unit controller, slave = UART/pipeline/memory side.
interface debug_unit_ctrl_if #(
   parameter int NB_REG  = 32,
   parameter int NB_BYTE = 8
);

   logic [NB_BYTE-1:0] i_rx_data;
   logic               i_rx_valid;
   logic               i_halt;
   logic [NB_REG-1:0]  i_pc;
   logic               i_tx_done;
   logic [NB_BYTE-1:0] o_tx_data;
   logic               o_tx_start;
   logic               o_dunit_clk_en;
   logic               o_dunit_w_en;
   logic [NB_REG-1:0]  o_dunit_mem_addr;
   logic [NB_REG-1:0]  o_dunit_mem_data;

   modport master (
      input  i_rx_data, i_rx_valid, i_halt, i_pc, i_tx_done,
      output o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_w_en,
             o_dunit_mem_addr, o_dunit_mem_data
   );

   modport slave (
      output i_rx_data, i_rx_valid, i_halt, i_pc, i_tx_done,
      input  o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_w_en,
             o_dunit_mem_addr, o_dunit_mem_data
   );

endinterface

// File: rtl/dunit_tx_serializer.sv
// Sends a captured word to the UART transmitter as 4 bytes, MSB first.
// Latency: first o_tx_start one cycle after i_load; each next start one cycle after i_tx_done.
// Backpressure: waits for i_tx_done per byte; o_busy stays high until the last done.
//
// Ports: i_load/i_word capture the word; o_tx_data/o_tx_start/i_tx_done form the
// transmitter handshake; o_last_done flags the cycle of the final i_tx_done.
module dunit_tx_serializer #(
   parameter int NB_REG  = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [NB_REG-1:0]  i_word,
   input  logic               i_tx_done,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_last_done
);

   // Holds only the bytes not yet handed to the transmitter.
   logic [NB_REG-NB_BYTE-1:0] rest_q;
   logic [1:0]                byte_idx;

   assign o_last_done = o_busy && i_tx_done && (byte_idx == 2'd3);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rest_q     <= '0;
         byte_idx   <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         if (i_load) begin
            o_tx_data  <= i_word[NB_REG-1 -: NB_BYTE];
            rest_q     <= i_word[NB_REG-NB_BYTE-1:0];
            byte_idx   <= '0;
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
         end else if (o_busy && i_tx_done) begin
            if (byte_idx == 2'd3) begin
               o_busy <= 1'b0;
            end else begin
               // o_tx_data only changes here, so it is stable for the whole byte.
               o_tx_data  <= rest_q[NB_REG-NB_BYTE-1 -: NB_BYTE];
               rest_q     <= rest_q << NB_BYTE;
               byte_idx   <= byte_idx + 2'd1;
               o_tx_start <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug-unit controller: UART command decode, program load, run/step clock gating, PC report.
// Latency: memory write one cycle after the 4th data byte; clk_en one cycle after 'C'/'S'.
// Backpressure: none on rx (bytes outside accepting states are dropped); tx waits on i_tx_done.
//
// Ports: i_clk, i_reset (async, active-low); dbg carries UART rx/tx, i_halt/i_pc from
// the pipeline and the registered debug ports o_dunit_clk_en/w_en/mem_addr/mem_data.
module debug_unit_ctrl #(
   parameter int NB_REG   = 32,
   parameter int NB_WIDHT = 9,
   parameter int NB_BYTE  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   debug_unit_ctrl_if.master    dbg
);

   import dunit_pkg::*;

   localparam int NB_IDX = NB_WIDHT - 2;

   dunit_state_t         state;
   logic [3*NB_BYTE-1:0] shift_q;     // first three bytes of the word in flight
   logic [1:0]           byte_cnt;
   logic [NB_IDX-1:0]    word_idx;    // wraps naturally at 2**(NB_WIDHT-2)
   logic [NB_BYTE-1:0]   words_left;

   logic                 clk_en_q;
   logic                 w_en_q;
   logic [NB_REG-1:0]    mem_addr_q;
   logic [NB_REG-1:0]    mem_data_q;

   logic                 tx_load;
   logic                 tx_busy;
   logic                 tx_last_done;
   logic [NB_BYTE-1:0]   tx_data;
   logic                 tx_start;

   // PC is captured on the edge that enters SEND.
   assign tx_load = ((state == RUN) && dbg.i_halt) || (state == STEP);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= IDLE;
         shift_q    <= '0;
         byte_cnt   <= '0;
         word_idx   <= '0;
         words_left <= '0;
         clk_en_q   <= 1'b0;
         w_en_q     <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         w_en_q <= 1'b0;
         case (state)
            IDLE: begin
               if (dbg.i_rx_valid) begin
                  case (dbg.i_rx_data)
                     CMD_LOAD: state <= LOAD_CNT;
                     CMD_RUN: begin
                        // Already halted: RUN spends one cycle with the clock gated.
                        clk_en_q <= ~dbg.i_halt;
                        state    <= RUN;
                     end
                     CMD_STEP: begin
                        clk_en_q <= 1'b1;
                        state    <= STEP;
                     end
                     default: ;
                  endcase
               end
            end
            LOAD_CNT: begin
               if (dbg.i_rx_valid) begin
                  if (dbg.i_rx_data == '0) begin
                     state <= IDLE;
                  end else begin
                     words_left <= dbg.i_rx_data;
                     word_idx   <= '0;
                     byte_cnt   <= '0;
                     state      <= LOAD_BYTE;
                  end
               end
            end
            LOAD_BYTE: begin
               if (dbg.i_rx_valid) begin
                  if (byte_cnt == 2'd3) begin
                     w_en_q     <= 1'b1;
                     mem_addr_q <= NB_REG'({word_idx, 2'b00});
                     mem_data_q <= NB_REG'({shift_q, dbg.i_rx_data});
                     byte_cnt   <= '0;
                     state      <= LOAD_WRITE;
                  end else begin
                     shift_q  <= {shift_q[2*NB_BYTE-1:0], dbg.i_rx_data};
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            LOAD_WRITE: begin
               word_idx   <= word_idx + NB_IDX'(1);
               words_left <= words_left - NB_BYTE'(1);
               state      <= (words_left == NB_BYTE'(1)) ? IDLE : LOAD_BYTE;
            end
            RUN: begin
               if (dbg.i_halt) begin
                  clk_en_q <= 1'b0;
                  state    <= SEND;
               end else begin
                  clk_en_q <= 1'b1;
               end
            end
            STEP: begin
               clk_en_q <= 1'b0;
               state    <= SEND;
            end
            SEND: begin
               if (tx_last_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   dunit_tx_serializer #(
      .NB_REG  (NB_REG),
      .NB_BYTE (NB_BYTE)
   ) u_tx_ser (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_load      (tx_load),
      .i_word      (dbg.i_pc),
      .i_tx_done   (dbg.i_tx_done),
      .o_tx_data   (tx_data),
      .o_tx_start  (tx_start),
      .o_busy      (tx_busy),
      .o_last_done (tx_last_done)
   );

   assign dbg.o_tx_data        = tx_data;
   assign dbg.o_tx_start       = tx_start;
   assign dbg.o_dunit_clk_en   = clk_en_q;
   assign dbg.o_dunit_w_en     = w_en_q;
   assign dbg.o_dunit_mem_addr = mem_addr_q;
   assign dbg.o_dunit_mem_data = mem_data_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Scoreboard bench for debug_unit_ctrl: directed UART byte streams, expected writes and
// tx bytes queued by the stimulus, checked by an independent monitor; a responder
// process answers every o_tx_start with i_tx_done a few cycles later.
module tb_debug_unit_ctrl;

   import dunit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   debug_unit_ctrl_if #(.NB_REG(32), .NB_BYTE(8)) dif ();

   debug_unit_ctrl #(
      .NB_REG   (32),
      .NB_WIDHT (9),
      .NB_BYTE  (8)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .dbg     (dif)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_tx[$];
   wr_t        mon_wr;
   int         total = 0;
   int         bad = 0;
   int         clk_cnt = 0;
   logic       tx_pending = 1'b0;
   logic [7:0] cur_tx = '0;
   logic [7:0] load_seq [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      dif.i_rx_data  = b;
      dif.i_rx_valid = 1'b1;
      tick();
      dif.i_rx_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      send_byte(b);
      repeat (2) tick();
   endtask

   task automatic push_pc(input logic [31:0] pc);
      exp_tx.push_back(pc[31:24]);
      exp_tx.push_back(pc[23:16]);
      exp_tx.push_back(pc[15:8]);
      exp_tx.push_back(pc[7:0]);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_wr.size() != 0 || exp_tx.size() != 0 || tx_pending) && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (exp_wr.size() != 0 || exp_tx.size() != 0 || tx_pending) begin
         bad++;
         $display("FAIL %s_timeout: %0d writes and %0d tx bytes outstanding, required 0",
                  name, exp_wr.size(), exp_tx.size());
      end
      repeat (3) tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_clk_en"},   32'(dif.o_dunit_clk_en),  32'h0);
      check({tag, "_w_en"},     32'(dif.o_dunit_w_en),    32'h0);
      check({tag, "_mem_addr"}, dif.o_dunit_mem_addr,     32'h0);
      check({tag, "_mem_data"}, dif.o_dunit_mem_data,     32'h0);
      check({tag, "_tx_start"}, 32'(dif.o_tx_start),      32'h0);
      check({tag, "_tx_data"},  32'(dif.o_tx_data),       32'h0);
   endtask

   // Monitor: compares every write and tx byte against the queued expectations.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dif.o_dunit_clk_en) clk_cnt++;
         if (dif.o_dunit_w_en) begin
            if (exp_wr.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr %h data %h, required no write",
                        dif.o_dunit_mem_addr, dif.o_dunit_mem_data);
            end else begin
               mon_wr = exp_wr.pop_front();
               check("wr_addr", dif.o_dunit_mem_addr, mon_wr.addr);
               check("wr_data", dif.o_dunit_mem_data, mon_wr.data);
               check("wr_clk_en_low", 32'(dif.o_dunit_clk_en), 32'h0);
            end
         end
         if (dif.o_tx_start) begin
            check("tx_start_after_done", 32'(tx_pending), 32'h0);
            if (exp_tx.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tx: byte %h, required no transmit", dif.o_tx_data);
            end else begin
               cur_tx = exp_tx.pop_front();
               check("tx_byte", 32'(dif.o_tx_data), 32'(cur_tx));
            end
            tx_pending = 1'b1;
         end else if (dif.i_tx_done && tx_pending) begin
            check("tx_data_held", 32'(dif.o_tx_data), 32'(cur_tx));
            tx_pending = 1'b0;
         end
      end
   end

   // Transmitter model: done three cycles after each start.
   initial begin
      dif.i_tx_done = 1'b0;
      forever begin
         tick();
         while (dif.o_tx_start) begin
            repeat (3) tick();
            dif.i_tx_done = 1'b1;
            tick();
            dif.i_tx_done = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      dif.i_rx_data  = '0;
      dif.i_rx_valid = 1'b0;
      dif.i_halt     = 1'b0;
      dif.i_pc       = '0;
      load_seq = '{8'h4C, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // Two-word load
      clk_cnt = 0;
      exp_wr.push_back('{addr: 32'h0, data: 32'h12345678});
      exp_wr.push_back('{addr: 32'h4, data: 32'h9ABCDEF0});
      for (int i = 0; i < 10; i++) send_gap(load_seq[i]);
      wait_drain("load", 50);
      check("load_clk_en_cycles", 32'(clk_cnt), 32'd0);

      // Partial load aborted by reset: no write, outputs cleared
      send_gap(CMD_LOAD);
      send_gap(8'h01);
      send_gap(8'hAA);
      send_gap(8'hBB);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      check_outputs_zero("abort_reset");
      tick();
      rst_n = 1'b1;
      tick();

      // Run: halt rises so that clk_en is high for 10 cycles
      dif.i_pc = 32'h0000_0028;
      clk_cnt = 0;
      push_pc(32'h0000_0028);
      send_byte(CMD_RUN);
      repeat (9) tick();
      dif.i_halt = 1'b1;
      wait_drain("run", 200);
      dif.i_halt = 1'b0;
      check("run_clk_en_cycles", 32'(clk_cnt), 32'd10);

      // Step, with bytes arriving during SEND that must be dropped
      dif.i_pc = 32'h0000_0004;
      clk_cnt = 0;
      push_pc(32'h0000_0004);
      send_byte(CMD_STEP);
      repeat (3) tick();
      send_byte(CMD_LOAD);
      repeat (3) tick();
      send_byte(8'h01);
      wait_drain("step", 200);
      check("step_clk_en_cycles", 32'(clk_cnt), 32'd1);

      // Unknown byte in IDLE is ignored; next step behaves normally
      send_gap(8'h7F);
      dif.i_pc = 32'h0000_0008;
      clk_cnt = 0;
      push_pc(32'h0000_0008);
      send_byte(CMD_STEP);
      wait_drain("step2", 200);
      check("step2_clk_en_cycles", 32'(clk_cnt), 32'd1);

      // Run with halt already high: zero pipeline cycles, PC still reported
      dif.i_halt = 1'b1;
      dif.i_pc   = 32'h0000_0100;
      clk_cnt = 0;
      push_pc(32'h0000_0100);
      send_byte(CMD_RUN);
      wait_drain("halted_run", 200);
      check("halted_clk_en_cycles", 32'(clk_cnt), 32'd0);
      dif.i_halt = 1'b0;

      // 129-word load: word 128 wraps to address 0
      clk_cnt = 0;
      send_gap(CMD_LOAD);
      send_gap(8'd129);
      for (int i = 0; i < 129; i++) begin
         w = {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'h3C};
         exp_wr.push_back('{addr: 32'((i * 4) % 512), data: w});
         send_gap(w[31:24]);
         send_gap(w[23:16]);
         send_gap(w[15:8]);
         send_gap(w[7:0]);
      end
      wait_drain("wrap_load", 50);
      check("wrap_clk_en_cycles", 32'(clk_cnt), 32'd0);

      // Load must have ended in IDLE: a step is honoured
      dif.i_pc = 32'h0000_000C;
      clk_cnt = 0;
      push_pc(32'h0000_000C);
      send_byte(CMD_STEP);
      wait_drain("post_load_step", 200);
      check("post_load_step_clk_en", 32'(clk_cnt), 32'd1);

      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
